outport_arbiter: RTL

//  Read side of the router input buffers: one instance per output port (N,S,E,W,L).

---
 rtl/outport_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/outport_arbiter.sv
// Per-output-port round-robin arbiter over five input-queue heads with a registered valid/ready link.
// Define OUTPORT_WORMHOLE_LOCK_EN to hold the grant on one input from head flit to tail flit.
module outport_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_i,
  output logic [NUM_IN-1:0]            pop_req_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NUM_IN-1:0]            grant_o,
  output logic [CNT_WIDTH-1:0]         flit_cnt_o
);

  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    EMPTY,
    HOLD
  } state_t;

  state_t                st_q, st_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         win;
  logic                  found;
  logic                  slot_free;
  logic                  take;
  logic [NUM_IN-1:0]     req_eff;
  logic [NUM_IN-1:0]     win_oh;
  logic [DATA_WIDTH-1:0] win_data;
  logic [PW-1:0]         ptr_nxt;

  assign valid_o   = (st_q == HOLD);
  assign slot_free = !valid_o | ready_i;

`ifdef OUTPORT_WORMHOLE_LOCK_EN
  logic lock_q, lock_d;

  // grant_o still names the locked input: nothing else can win while locked
  assign req_eff = lock_q ? (req_i & grant_o) : req_i;
`else
  assign req_eff = req_i;
`endif

  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && req_eff[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign win_oh    = NUM_IN'(1) << win;
  assign win_data  = data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign take      = slot_free & found;
  assign pop_req_o = (take && !rst) ? win_oh : '0;
  assign ptr_nxt   = (win == PW'(NUM_IN - 1)) ? '0 : win + 1'b1;

  always_comb begin
    st_d  = st_q;
    ptr_d = ptr_q;
`ifdef OUTPORT_WORMHOLE_LOCK_EN
    lock_d = lock_q;
`endif
    if (take) begin
      st_d = HOLD;
`ifdef OUTPORT_WORMHOLE_LOCK_EN
      if (!win_data[DATA_WIDTH-1]) begin
        lock_d = 1'b1;
      end else begin
        lock_d = 1'b0;
        ptr_d  = ptr_nxt;
      end
`else
      ptr_d = ptr_nxt;
`endif
    end else if (slot_free) begin
      st_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= EMPTY;
      ptr_q <= '0;
`ifdef OUTPORT_WORMHOLE_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
`ifdef OUTPORT_WORMHOLE_LOCK_EN
      lock_q <= lock_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o     <= '0;
      grant_o    <= '0;
      flit_cnt_o <= '0;
    end else begin
      if (take) begin
        data_o  <= win_data;
        grant_o <= win_oh;
      end
      if (valid_o && ready_i) flit_cnt_o <= flit_cnt_o + 1'b1;
    end
  end

endmodule
